// File: rtl/ipif_regs_pkg.sv
// Shared types and helpers for the IPIF register file: handshake state
// encoding, bank decode tags and a minimum-one ceil-log2.
package ipif_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BANK_WO  = 3'd0,
        BANK_RW  = 3'd1,
        BANK_W1C = 3'd2,
        BANK_RO  = 3'd3,
        BANK_BAD = 3'd4
    } bank_t;

    // Index fields are never narrower than one bit, even for a single register.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ipif_regs_ext_if.sv
// IPIF bus bundle between axi_lite_ipif (master) and the register file (slave).
interface ipif_regs_ext_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   Bus2IP_Addr;
    logic            Bus2IP_CS;
    logic            Bus2IP_RNW;
    logic [DW-1:0]   Bus2IP_Data;
    logic [DW/8-1:0] Bus2IP_BE;
    logic [DW-1:0]   IP2Bus_Data;
    logic            IP2Bus_RdAck;
    logic            IP2Bus_WrAck;
    logic            IP2Bus_Error;

    modport master (
        output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

    modport slave (
        input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
endinterface

// File: rtl/ipif_be_merge.sv
// Byte-enable merge of a write into an existing register value; in w1c_mode
// the enabled bytes clear the bits written as 1 instead of replacing them.
module ipif_be_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_val,
    input  logic [DW-1:0]   new_val,
    input  logic [DW/8-1:0] be,
    input  logic            w1c_mode,
    output logic [DW-1:0]   merged
);
    for (genvar gi = 0; gi < DW/8; gi++) begin : g_byte
        assign merged[8*gi +: 8] = !be[gi]  ? old_val[8*gi +: 8] :
                                   w1c_mode ? (old_val[8*gi +: 8] & ~new_val[8*gi +: 8]) :
                                              new_val[8*gi +: 8];
    end
endmodule

// File: rtl/ipif_regs_ext.sv
// IPIF register file with WO, RW, W1C and RO banks at consecutive word
// addresses; one ack (with optional error) per CS assertion.
module ipif_regs_ext
    import ipif_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_WO_REGS        = 0,
    parameter int NUM_RW_REGS        = 0,
    parameter int NUM_W1C_REGS       = 0,
    parameter int NUM_RO_REGS        = 0,
    localparam int DW     = C_S_AXI_DATA_WIDTH,
    localparam int NWO_P  = (NUM_WO_REGS  > 0) ? NUM_WO_REGS  : 1,
    localparam int NRW_P  = (NUM_RW_REGS  > 0) ? NUM_RW_REGS  : 1,
    localparam int NW1C_P = (NUM_W1C_REGS > 0) ? NUM_W1C_REGS : 1,
    localparam int NRO_P  = (NUM_RO_REGS  > 0) ? NUM_RO_REGS  : 1
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Reset,
    ipif_regs_ext_if.slave        bus,
    output logic [NWO_P*DW-1:0]   wo_regs,
    input  logic [NWO_P*DW-1:0]   wo_defaults,
    output logic [NWO_P-1:0]      wo_wr_pulse,
    output logic [NRW_P*DW-1:0]   rw_regs,
    input  logic [NRW_P*DW-1:0]   rw_defaults,
    output logic [NRW_P-1:0]      rw_wr_pulse,
    input  logic [NW1C_P*DW-1:0]  w1c_set,
    output logic [NW1C_P*DW-1:0]  w1c_regs,
    input  logic [NRO_P*DW-1:0]   ro_regs,
    output logic [NRO_P-1:0]      ro_rd_pulse
);
    localparam int          TOTAL    = NUM_WO_REGS + NUM_RW_REGS + NUM_W1C_REGS + NUM_RO_REGS;
    localparam int          ADDR_LSB = clog2_min1(DW/8);
    localparam int          IDX_W    = clog2_min1(TOTAL);
    localparam int unsigned RW_BASE  = NUM_WO_REGS;
    localparam int unsigned W1C_BASE = RW_BASE + NUM_RW_REGS;
    localparam int unsigned RO_BASE  = W1C_BASE + NUM_W1C_REGS;
    localparam int unsigned END_IDX  = RO_BASE + NUM_RO_REGS;

    logic            clk;
    logic            rst;
    logic [IDX_W-1:0] idx;
    int unsigned     idx_u;
    int unsigned     off;
    bank_t           bank;
    logic            access_err;
    logic            access;
    logic            wr_ok;
    logic            rd_ok;
    logic [DW-1:0]   rd_val;

    state_t          state_reg, state_next;
    logic            rd_ack_reg, rd_ack_next;
    logic            wr_ack_reg, wr_ack_next;
    logic            err_reg, err_next;
    logic [DW-1:0]   data_reg, data_next;

    // Upper address bits and banks that may be empty are folded here on purpose.
    logic            unused_inputs;

    assign clk = Bus2IP_Clk;
    assign rst = Bus2IP_Reset;
    assign idx = bus.Bus2IP_Addr[ADDR_LSB +: IDX_W];
    assign unused_inputs = ^{bus.Bus2IP_Addr, bus.Bus2IP_Data, bus.Bus2IP_BE,
                             wo_defaults, rw_defaults, w1c_set, ro_regs};

    always_comb begin
        idx_u = {{(32-IDX_W){1'b0}}, idx};
        bank  = BANK_BAD;
        off   = 0;
        if (idx_u < RW_BASE) begin
            bank = BANK_WO;
            off  = idx_u;
        end else if (idx_u < W1C_BASE) begin
            bank = BANK_RW;
            off  = idx_u - RW_BASE;
        end else if (idx_u < RO_BASE) begin
            bank = BANK_W1C;
            off  = idx_u - W1C_BASE;
        end else if (idx_u < END_IDX) begin
            bank = BANK_RO;
            off  = idx_u - RO_BASE;
        end
    end

    assign access_err = (bank == BANK_BAD)
                     || ( bus.Bus2IP_RNW && (bank == BANK_WO))
                     || (!bus.Bus2IP_RNW && (bank == BANK_RO));
    assign access = (state_reg == ST_IDLE) && bus.Bus2IP_CS;
    assign wr_ok  = access && !bus.Bus2IP_RNW && !access_err;
    assign rd_ok  = access &&  bus.Bus2IP_RNW && !access_err;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_RW_REGS; i++)
            if ((bank == BANK_RW) && (off == i)) rd_val = rw_regs[DW*i +: DW];
        for (int i = 0; i < NUM_W1C_REGS; i++)
            if ((bank == BANK_W1C) && (off == i)) rd_val = w1c_regs[DW*i +: DW];
        for (int i = 0; i < NUM_RO_REGS; i++)
            if ((bank == BANK_RO) && (off == i)) rd_val = ro_regs[DW*i +: DW];
    end

    // Handshake FSM: access happens on the IDLE->ACK edge, ack lives only in ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            rd_ack_reg <= 1'b0;
            wr_ack_reg <= 1'b0;
            err_reg    <= 1'b0;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            rd_ack_reg <= rd_ack_next;
            wr_ack_reg <= wr_ack_next;
            err_reg    <= err_next;
            data_reg   <= data_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_ack_next = 1'b0;
        wr_ack_next = 1'b0;
        err_next    = 1'b0;
        data_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.Bus2IP_CS) begin
                    state_next  = ST_ACK;
                    rd_ack_next = bus.Bus2IP_RNW;
                    wr_ack_next = !bus.Bus2IP_RNW;
                    err_next    = access_err;
                    data_next   = rd_ok ? rd_val : '0;
                end
            end
            ST_ACK:  state_next = ST_WAIT;
            ST_WAIT: if (!bus.Bus2IP_CS) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.IP2Bus_RdAck = rd_ack_reg;
    assign bus.IP2Bus_WrAck = wr_ack_reg;
    assign bus.IP2Bus_Error = err_reg;
    assign bus.IP2Bus_Data  = data_reg;

    if (NUM_WO_REGS > 0) begin : g_wo
        for (genvar gi = 0; gi < NUM_WO_REGS; gi++) begin : g_reg
            logic [DW-1:0] q_reg;
            logic [DW-1:0] merged;
            logic          pulse_reg;
            logic          hit;
            assign hit = wr_ok && (bank == BANK_WO) && (off == gi);
            ipif_be_merge #(.DW(DW)) u_merge (
                .old_val (q_reg),
                .new_val (bus.Bus2IP_Data),
                .be      (bus.Bus2IP_BE),
                .w1c_mode(1'b0),
                .merged  (merged)
            );
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg     <= wo_defaults[DW*gi +: DW];
                    pulse_reg <= 1'b0;
                end else begin
                    if (hit) q_reg <= merged;
                    pulse_reg <= hit;
                end
            end
            assign wo_regs[DW*gi +: DW] = q_reg;
            assign wo_wr_pulse[gi]      = pulse_reg;
        end
    end else begin : g_no_wo
        assign wo_regs     = '0;
        assign wo_wr_pulse = '0;
    end

    if (NUM_RW_REGS > 0) begin : g_rw
        for (genvar gi = 0; gi < NUM_RW_REGS; gi++) begin : g_reg
            logic [DW-1:0] q_reg;
            logic [DW-1:0] merged;
            logic          pulse_reg;
            logic          hit;
            assign hit = wr_ok && (bank == BANK_RW) && (off == gi);
            ipif_be_merge #(.DW(DW)) u_merge (
                .old_val (q_reg),
                .new_val (bus.Bus2IP_Data),
                .be      (bus.Bus2IP_BE),
                .w1c_mode(1'b0),
                .merged  (merged)
            );
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg     <= rw_defaults[DW*gi +: DW];
                    pulse_reg <= 1'b0;
                end else begin
                    if (hit) q_reg <= merged;
                    pulse_reg <= hit;
                end
            end
            assign rw_regs[DW*gi +: DW] = q_reg;
            assign rw_wr_pulse[gi]      = pulse_reg;
        end
    end else begin : g_no_rw
        assign rw_regs     = '0;
        assign rw_wr_pulse = '0;
    end

    if (NUM_W1C_REGS > 0) begin : g_w1c
        for (genvar gi = 0; gi < NUM_W1C_REGS; gi++) begin : g_reg
            logic [DW-1:0] q_reg;
            logic [DW-1:0] merged;
            logic          hit;
            assign hit = wr_ok && (bank == BANK_W1C) && (off == gi);
            ipif_be_merge #(.DW(DW)) u_merge (
                .old_val (q_reg),
                .new_val (bus.Bus2IP_Data),
                .be      (bus.Bus2IP_BE),
                .w1c_mode(1'b1),
                .merged  (merged)
            );
            // OR-ing the set vector after the clear lets hardware events win a race with software.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q_reg <= '0;
                else     q_reg <= (hit ? merged : q_reg) | w1c_set[DW*gi +: DW];
            end
            assign w1c_regs[DW*gi +: DW] = q_reg;
        end
    end else begin : g_no_w1c
        assign w1c_regs = '0;
    end

    if (NUM_RO_REGS > 0) begin : g_ro
        for (genvar gi = 0; gi < NUM_RO_REGS; gi++) begin : g_reg
            logic pulse_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pulse_reg <= 1'b0;
                else     pulse_reg <= rd_ok && (bank == BANK_RO) && (off == gi);
            end
            assign ro_rd_pulse[gi] = pulse_reg;
        end
    end else begin : g_no_ro
        assign ro_rd_pulse = '0;
    end

endmodule

// File: tb/tb_ipif_regs_ext.sv
// Directed bench for ipif_regs_ext: 2 WO, 2 RW, 1 W1C, 1 RO register at
// word indices 0..5; indices 6 and 7 are out of range.
module tb_ipif_regs_ext;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ipif_regs_ext_if #(.DW(32), .AW(32)) bus_if ();

    logic [2*DW-1:0] wo_regs;
    logic [2*DW-1:0] wo_defaults;
    logic [1:0]      wo_wr_pulse;
    logic [2*DW-1:0] rw_regs;
    logic [2*DW-1:0] rw_defaults;
    logic [1:0]      rw_wr_pulse;
    logic [DW-1:0]   w1c_set;
    logic [DW-1:0]   w1c_regs;
    logic [DW-1:0]   ro_regs;
    logic [0:0]      ro_rd_pulse;

    ipif_regs_ext #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .NUM_WO_REGS (2),
        .NUM_RW_REGS (2),
        .NUM_W1C_REGS(1),
        .NUM_RO_REGS (1)
    ) dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .bus         (bus_if),
        .wo_regs     (wo_regs),
        .wo_defaults (wo_defaults),
        .wo_wr_pulse (wo_wr_pulse),
        .rw_regs     (rw_regs),
        .rw_defaults (rw_defaults),
        .rw_wr_pulse (rw_wr_pulse),
        .w1c_set     (w1c_set),
        .w1c_regs    (w1c_regs),
        .ro_regs     (ro_regs),
        .ro_rd_pulse (ro_rd_pulse)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raise CS and wait for an ack; lat counts clock edges until it appears.
    task automatic start(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int lat);
        bus_if.Bus2IP_Addr = addr;
        bus_if.Bus2IP_RNW  = rnw;
        bus_if.Bus2IP_Data = data;
        bus_if.Bus2IP_BE   = be;
        bus_if.Bus2IP_CS   = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(bus_if.IP2Bus_RdAck || bus_if.IP2Bus_WrAck) && lat < 8);
        $display("txn %s addr=%h wdata=%h be=%b rdata=%h err=%b lat=%0d",
                 rnw ? "RD" : "WR", addr, data, be, bus_if.IP2Bus_Data, bus_if.IP2Bus_Error, lat);
    endtask

    task automatic finish_acc();
        bus_if.Bus2IP_CS = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    int lat;
    int cyc;
    int n_ack;
    int first_ack;
    logic [31:0] seen_data;

    initial begin
        bus_if.Bus2IP_Addr = '0;
        bus_if.Bus2IP_RNW  = 1'b0;
        bus_if.Bus2IP_Data = '0;
        bus_if.Bus2IP_BE   = '0;
        bus_if.Bus2IP_CS   = 1'b0;
        wo_defaults = {32'h0000_0022, 32'h0000_0011};
        rw_defaults = {32'h1234_5678, 32'h0000_0000};
        w1c_set     = '0;
        ro_regs     = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_wo",    wo_regs, 64'h0000_0022_0000_0011);
        chk("rst_rw",    rw_regs, 64'h1234_5678_0000_0000);
        chk("rst_w1c",   w1c_regs, 64'h0);
        chk("rst_acks",  {bus_if.IP2Bus_RdAck, bus_if.IP2Bus_WrAck, bus_if.IP2Bus_Error}, 64'h0);
        chk("rst_data",  bus_if.IP2Bus_Data, 64'h0);

        // Read of WO is an error with zero data
        start(1'b1, 32'h0, 32'h0, 4'h0, lat);
        chk("wo_rd_lat",   lat, 64'd1);
        chk("wo_rd_ack",   bus_if.IP2Bus_RdAck, 64'd1);
        chk("wo_rd_err",   bus_if.IP2Bus_Error, 64'd1);
        chk("wo_rd_data",  bus_if.IP2Bus_Data, 64'h0);
        finish_acc();

        // RW byte-enable write
        start(1'b0, 32'h8, 32'hAABB_CCDD, 4'b0101, lat);
        chk("rw_wr_lat",   lat, 64'd1);
        chk("rw_wr_ack",   {bus_if.IP2Bus_WrAck, bus_if.IP2Bus_RdAck, bus_if.IP2Bus_Error}, 64'b100);
        chk("rw_wr_val",   rw_regs, 64'h1234_5678_00BB_00DD);
        chk("rw_wr_pulse", rw_wr_pulse, 64'b01);
        @(posedge clk); #1;
        chk("rw_ack_once", bus_if.IP2Bus_WrAck, 64'd0);
        chk("rw_pls_once", rw_wr_pulse, 64'b00);
        finish_acc();

        // Hold CS through a long read: single ack in cycle 2
        bus_if.Bus2IP_Addr = 32'h8;
        bus_if.Bus2IP_RNW  = 1'b1;
        bus_if.Bus2IP_CS   = 1'b1;
        cyc = 1; n_ack = 0; first_ack = 0; seen_data = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_if.IP2Bus_RdAck) begin
                n_ack++;
                if (first_ack == 0) begin
                    first_ack = cyc;
                    seen_data = bus_if.IP2Bus_Data;
                end
            end
        end
        $display("txn RD addr=00000008 held 6 cycles acks=%0d first=%0d rdata=%h", n_ack, first_ack, seen_data);
        chk("hold_nack",  n_ack, 64'd1);
        chk("hold_cycle", first_ack, 64'd2);
        chk("hold_data",  seen_data, 64'h00BB_00DD);
        finish_acc();
        start(1'b1, 32'h8, 32'h0, 4'h0, lat);
        chk("rerd_lat",   lat, 64'd1);
        chk("rerd_data",  bus_if.IP2Bus_Data, 64'h00BB_00DD);
        finish_acc();

        // W1C: set, clear racing a set, plain clear, non-destructive reads
        w1c_set = 32'h5;
        @(posedge clk); #1;
        w1c_set = 32'h0;
        chk("w1c_set",    w1c_regs, 64'h5);
        start(1'b1, 32'h10, 32'h0, 4'h0, lat);
        chk("w1c_rd",     bus_if.IP2Bus_Data, 64'h5);
        chk("w1c_rd_err", bus_if.IP2Bus_Error, 64'd0);
        finish_acc();
        w1c_set = 32'h1;
        start(1'b0, 32'h10, 32'h1, 4'hF, lat);
        w1c_set = 32'h0;
        chk("w1c_race",   w1c_regs, 64'h5);
        finish_acc();
        start(1'b0, 32'h10, 32'h4, 4'hF, lat);
        chk("w1c_clr",    w1c_regs, 64'h1);
        finish_acc();
        start(1'b0, 32'h10, 32'hFFFF_FFFF, 4'h0, lat);
        chk("w1c_be0",    w1c_regs, 64'h1);
        finish_acc();
        start(1'b1, 32'h10, 32'h0, 4'h0, lat);
        chk("w1c_rd1",    bus_if.IP2Bus_Data, 64'h1);
        finish_acc();
        start(1'b1, 32'h10, 32'h0, 4'h0, lat);
        chk("w1c_rd2",    bus_if.IP2Bus_Data, 64'h1);
        finish_acc();

        // RO read with clear-on-read pulse
        ro_regs = 32'hDEAD_BEEF;
        start(1'b1, 32'h14, 32'h0, 4'h0, lat);
        chk("ro_rd_data", bus_if.IP2Bus_Data, 64'hDEAD_BEEF);
        chk("ro_rd_err",  bus_if.IP2Bus_Error, 64'd0);
        chk("ro_pulse",   ro_rd_pulse, 64'd1);
        @(posedge clk); #1;
        chk("ro_pls_once", ro_rd_pulse, 64'd0);
        finish_acc();

        // Error writes: RO, index == total; error read above range
        start(1'b0, 32'h14, 32'h0, 4'hF, lat);
        chk("ro_wr_ack",  {bus_if.IP2Bus_WrAck, bus_if.IP2Bus_Error}, 64'b11);
        finish_acc();
        start(1'b0, 32'h18, 32'hFFFF_FFFF, 4'hF, lat);
        chk("oor_wr_err", {bus_if.IP2Bus_WrAck, bus_if.IP2Bus_Error}, 64'b11);
        chk("oor_wr_pls", {wo_wr_pulse, rw_wr_pulse}, 64'h0);
        chk("oor_wr_rw",  rw_regs, 64'h1234_5678_00BB_00DD);
        chk("oor_wr_wo",  wo_regs, 64'h0000_0022_0000_0011);
        finish_acc();
        start(1'b1, 32'h1C, 32'h0, 4'h0, lat);
        chk("oor_rd_err", {bus_if.IP2Bus_RdAck, bus_if.IP2Bus_Error}, 64'b11);
        chk("oor_rd_dat", bus_if.IP2Bus_Data, 64'h0);
        finish_acc();

        // WO: BE=0 still pulses; upper address bits ignored; full write
        start(1'b0, 32'h1000_0004, 32'hFFFF_FFFF, 4'h0, lat);
        chk("wo_be0_err", bus_if.IP2Bus_Error, 64'd0);
        chk("wo_be0_pls", wo_wr_pulse, 64'b10);
        chk("wo_be0_val", wo_regs, 64'h0000_0022_0000_0011);
        finish_acc();
        start(1'b0, 32'h0, 32'h5566_7788, 4'hF, lat);
        chk("wo_wr_val",  wo_regs, 64'h0000_0022_5566_7788);
        chk("wo_wr_pls",  wo_wr_pulse, 64'b01);
        finish_acc();

        // Reset while in ACK aborts and restores defaults
        start(1'b0, 32'hC, 32'hCAFE_F00D, 4'hF, lat);
        chk("pre_rst_rw", rw_regs, 64'hCAFE_F00D_00BB_00DD);
        chk("pre_rst_ak", bus_if.IP2Bus_WrAck, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ak", {bus_if.IP2Bus_WrAck, bus_if.IP2Bus_Error}, 64'b00);
        chk("mid_rst_rw", rw_regs, 64'h1234_5678_0000_0000);
        chk("mid_rst_wo", wo_regs, 64'h0000_0022_0000_0011);
        chk("mid_rst_pl", rw_wr_pulse, 64'b00);
        bus_if.Bus2IP_CS = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start(1'b1, 32'hC, 32'h0, 4'h0, lat);
        chk("post_rst_lat", lat, 64'd1);
        chk("post_rst_rd",  bus_if.IP2Bus_Data, 64'h1234_5678);
        finish_acc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
